// File: rtl/clmul_slice_pkg.sv
// Shared definitions for the serial carry-less multiply slice.
//   state_e : FSM states (IDLE, RUN, DONE)
//   OP_W    : operand width (8)
//   Y_W     : result width (7)
//   ACC_W   : full carry-less product width (15)
//   Y_OFS   : bit offset of the upper product slice taken into y (8)
//   clmul8  : plain carry-less 8x8 product, for reference use
package clmul_slice_pkg;

   localparam int OP_W  = 8;
   localparam int Y_W   = 7;
   localparam int ACC_W = 15;
   localparam int Y_OFS = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic [ACC_W-1:0] clmul8(input logic [OP_W-1:0] a,
                                               input logic [OP_W-1:0] b);
      logic [ACC_W-1:0] p;
      p = '0;
      for (int j = 0; j < OP_W; j++) begin
         if (b[j]) p = p ^ (ACC_W'(a) << j);
      end
      return p;
   endfunction

endpackage

// File: rtl/clmul_step.sv
// One serial step of a carry-less multiply: folds BPC bits of the b operand
// into the accumulator. The a operand arrives pre-shifted to the position of
// b_i[0], so bit t of b_i contributes a_i << t.
//   acc_i : accumulator before this step
//   a_i   : a operand, already aligned to the current b bit position
//   b_i   : the next BPC bits of b, LSB first
//   acc_o : accumulator after this step (purely combinational)
module clmul_step
   import clmul_slice_pkg::*;
#(
   parameter int BPC = 1
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [ACC_W-1:0] a_i,
   input  logic [BPC-1:0]   b_i,
   output logic [ACC_W-1:0] acc_o
);

   // NOTE: combinational blocks use blocking '=' so later lines see the
   // updated value; acc_o gets its default first so no latch can form.
   always_comb begin
      acc_o = acc_i;
      for (int t = 0; t < BPC; t++) begin
         if (b_i[t]) acc_o = acc_o ^ (a_i << t);
      end
   end

endmodule

// File: rtl/clmul_slice_serial.sv
// Serial carry-less multiply slice:
//   y = clmul(a0,b0)[14:8] ^ clmul(a1,b1)[6:0]
// computed BPC bits of b per clock over N = 8/BPC RUN cycles.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : operand handshake (ready only in IDLE)
//   a0, b0, a1, b1     : 8-bit GF(2) polynomial operands
//   out_valid/out_ready: result handshake (valid only in DONE)
//   y                  : 7-bit registered result
//   busy               : FSM is not in IDLE
// BPC must be 1, 2, 4 or 8.
module clmul_slice_serial
   import clmul_slice_pkg::*;
#(
   parameter int BPC = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OP_W-1:0] a0,
   input  logic [OP_W-1:0] b0,
   input  logic [OP_W-1:0] a1,
   input  logic [OP_W-1:0] b1,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [Y_W-1:0]  y,
   output logic            busy
);

   localparam int         N    = OP_W / BPC;
   localparam logic [2:0] LAST = 3'(N - 1);

   state_e           state_q, state_d;
   logic [ACC_W-1:0] a0_q, a0_d, a1_q, a1_d;
   logic [OP_W-1:0]  b0_q, b0_d, b1_q, b1_d;
   logic [ACC_W-1:0] acc0_q, acc0_d, acc1_q, acc1_d;
   logic [ACC_W-1:0] acc0_step, acc1_step;
   logic [2:0]       cnt_q, cnt_d;
   logic [Y_W-1:0]   y_q, y_d;

   // a is held pre-shifted and b is consumed from its LSB, so each step
   // always looks at b[BPC-1:0] and a needs no variable shifter.
   clmul_step #(.BPC(BPC)) u_step0 (
      .acc_i (acc0_q),
      .a_i   (a0_q),
      .b_i   (b0_q[BPC-1:0]),
      .acc_o (acc0_step)
   );

   clmul_step #(.BPC(BPC)) u_step1 (
      .acc_i (acc1_q),
      .a_i   (a1_q),
      .b_i   (b1_q[BPC-1:0]),
      .acc_o (acc1_step)
   );

   always_comb begin
      state_d = state_q;
      a0_d    = a0_q;
      a1_d    = a1_q;
      b0_d    = b0_q;
      b1_d    = b1_q;
      acc0_d  = acc0_q;
      acc1_d  = acc1_q;
      cnt_d   = cnt_q;
      y_d     = y_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a0_d    = ACC_W'(a0);
               a1_d    = ACC_W'(a1);
               b0_d    = b0;
               b1_d    = b1;
               acc0_d  = '0;
               acc1_d  = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            acc0_d = acc0_step;
            acc1_d = acc1_step;
            a0_d   = a0_q << BPC;
            a1_d   = a1_q << BPC;
            b0_d   = b0_q >> BPC;
            b1_d   = b1_q >> BPC;
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == LAST) begin
               // Capture the result from the final step so y is registered
               // on the same edge that enters DONE.
               y_d     = acc0_step[ACC_W-1:Y_OFS] ^ acc1_step[Y_W-1:0];
               state_d = DONE;
            end
         end

         DONE: begin
            if (out_ready) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples
   // its _d value from before the edge. The operand registers are plain
   // flops, not a memory, so they are reset along with everything else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a0_q    <= '0;
         a1_q    <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         acc0_q  <= '0;
         acc1_q  <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         a0_q    <= a0_d;
         a1_q    <= a1_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         acc0_q  <= acc0_d;
         acc1_q  <= acc1_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
      end
   end

   // All outputs decode registered state only; no input reaches an output
   // combinationally.
   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign y         = y_q;

endmodule

// File: tb/tb_clmul_slice_serial.sv
// Self-checking bench for clmul_slice_serial. Four instances (BPC = 1, 2, 4,
// 8) share clock and reset; directed steps exercise latency, stalls and reset
// abort, then randomized back-to-back traffic is compared against a
// coefficient-sum reference model.
module tb_clmul_slice_serial;

   logic       clk;
   logic       rst_n;
   logic       in_valid  [4];
   logic       in_ready  [4];
   logic [7:0] a0        [4];
   logic [7:0] b0        [4];
   logic [7:0] a1        [4];
   logic [7:0] b1        [4];
   logic       out_valid [4];
   logic       out_ready [4];
   logic [6:0] y         [4];
   logic       busy      [4];

   int total = 0;
   int bad   = 0;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      clmul_slice_serial #(.BPC(1 << g)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .a0        (a0[g]),
         .b0        (b0[g]),
         .a1        (a1[g]),
         .b1        (b1[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .y         (y[g]),
         .busy      (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Reference: y[k] = XOR_{i+j=k+8} a0[i]b0[j]  ^  XOR_{i+j=k} a1[i]b1[j]
   function automatic logic [6:0] ref_y(input logic [7:0] x0, input logic [7:0] z0,
                                        input logic [7:0] x1, input logic [7:0] z1);
      logic [6:0] r;
      r = '0;
      for (int k = 0; k < 7; k++) begin
         for (int i = 0; i < 8; i++) begin
            int j;
            j = k + 8 - i;
            if (j >= 0 && j < 8) r[k] = r[k] ^ (x0[i] & z0[j]);
            j = k - i;
            if (j >= 0) r[k] = r[k] ^ (x1[i] & z1[j]);
         end
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present operands at a negedge, let the next posedge accept them, then
   // scramble the inputs. Returns at the negedge of the first RUN cycle.
   task automatic do_accept(input int k, input logic [7:0] x0, input logic [7:0] z0,
                            input logic [7:0] x1, input logic [7:0] z1);
      @(negedge clk);
      a0[k] = x0; b0[k] = z0; a1[k] = x1; b1[k] = z1;
      in_valid[k] = 1'b1;
      check("accept_in_ready", in_ready[k], 1);
      @(posedge clk);
      @(negedge clk);
      in_valid[k] = 1'b0;
      a0[k] = 8'($urandom); b0[k] = 8'($urandom);
      a1[k] = 8'($urandom); b1[k] = 8'($urandom);
      check("run_busy", busy[k], 1);
      check("run_in_ready", in_ready[k], 0);
   endtask

   // From the first RUN negedge, out_valid must appear exactly N edges later.
   task automatic wait_out(input int k, input logic [6:0] exp_y);
      int n;
      n = 8 >> k;
      check("ov_first_run", out_valid[k], 0);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         check("ov_latency", out_valid[k], (c == n) ? 1 : 0);
      end
      check("result_y", y[k], exp_y);
   endtask

   task automatic take(input int k);
      out_ready[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready[k] = 1'b0;
      check("post_take_in_ready", in_ready[k], 1);
      check("post_take_out_valid", out_valid[k], 0);
      check("post_take_busy", busy[k], 0);
   endtask

   task automatic run_random(input int k, input int nops);
      int         n;
      logic [6:0] expq[$];
      int         sent;
      int         got;
      int         last_acc;
      bit         swap;
      n        = 8 >> k;
      sent     = 0;
      got      = 0;
      last_acc = -1;
      swap     = 1'b0;
      @(negedge clk);
      a0[k] = 8'($urandom); b0[k] = 8'($urandom);
      a1[k] = 8'($urandom); b1[k] = 8'($urandom);
      in_valid[k]  = 1'b1;
      out_ready[k] = 1'b1;
      for (int cyc = 0; cyc < nops * (n + 2) + 40 && got < nops; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (swap) begin
            swap = 1'b0;
            if (sent < nops) begin
               a0[k] = 8'($urandom); b0[k] = 8'($urandom);
               a1[k] = 8'($urandom); b1[k] = 8'($urandom);
            end else begin
               in_valid[k] = 1'b0;
            end
         end
         if (out_valid[k]) begin
            if (expq.size() == 0) begin
               check("rand_spurious_ov", out_valid[k], 0);
            end else begin
               check("rand_y", y[k], expq.pop_front());
               got++;
            end
         end
         if (in_valid[k] && in_ready[k]) begin
            expq.push_back(ref_y(a0[k], b0[k], a1[k], b1[k]));
            if (last_acc >= 0) check("rand_ii", cyc - last_acc, n + 2);
            last_acc = cyc;
            sent++;
            swap = 1'b1;
         end
      end
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      check("rand_count", got, nops);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid[k] = 1'b0; out_ready[k] = 1'b0;
         a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check("rst_in_ready", in_ready[k], 1);
         check("rst_out_valid", out_valid[k], 0);
         check("rst_busy", busy[k], 0);
         check("rst_y", y[k], 0);
      end
      rst_n = 1'b1;

      // Basic latency and result for every BPC
      for (int k = 0; k < 4; k++) begin
         do_accept(k, 8'h00, 8'h00, 8'h01, 8'h01);
         wait_out(k, 7'h01);
         take(k);
      end

      // Directed values on BPC=1
      do_accept(0, 8'h80, 8'h80, 8'h03, 8'h03);
      wait_out(0, 7'h45);
      take(0);
      do_accept(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      wait_out(0, 7'h00);
      take(0);
      do_accept(0, 8'h80, 8'h01, 8'h00, 8'h00);
      wait_out(0, 7'h00);
      take(0);
      do_accept(0, 8'h00, 8'h00, 8'h00, 8'h00);
      wait_out(0, 7'h00);
      take(0);

      // Output stall with a new request held off meanwhile
      do_accept(0, 8'h80, 8'h80, 8'h03, 8'h03);
      wait_out(0, 7'h45);
      a0[0] = 8'h12; b0[0] = 8'h34; a1[0] = 8'h56; b1[0] = 8'h78;
      in_valid[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_out_valid", out_valid[0], 1);
         check("stall_y", y[0], 7'h45);
         check("stall_in_ready", in_ready[0], 0);
      end
      out_ready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready[0] = 1'b0;
      check("stall_release_in_ready", in_ready[0], 1);
      check("stall_release_out_valid", out_valid[0], 0);
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      check("held_req_busy", busy[0], 1);
      wait_out(0, ref_y(8'h12, 8'h34, 8'h56, 8'h78));
      take(0);

      // Reset asserted in the third RUN cycle aborts the operation
      do_accept(0, 8'hA5, 8'h5A, 8'h3C, 8'hC3);
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_in_ready", in_ready[0], 1);
      check("abort_out_valid", out_valid[0], 0);
      check("abort_busy", busy[0], 0);
      check("abort_y", y[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check("abort_no_out_valid", out_valid[0], 0);
      end
      do_accept(0, 8'hA5, 8'h5A, 8'h3C, 8'hC3);
      wait_out(0, ref_y(8'hA5, 8'h5A, 8'h3C, 8'hC3));
      take(0);

      // Randomized back-to-back traffic for each BPC
      for (int k = 0; k < 4; k++) run_random(k, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clmul_slice_serial.md
CLMUL_SLICE_SERIAL -- requirements
Module: clmul_slice_serial

Interface
REQ-001 Parameter BPC, default 1, means b-operand bits processed per clock; the legal values SHALL be 1, 2, 4 and 8.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port in_valid, input, 1 bit: the operand set on a0/b0/a1/b1 is valid.
REQ-005 Port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-006 Ports a0, b0, a1 and b1, input, 8 bits each: GF(2) polynomial operands, bit i = coefficient of x^i.
REQ-007 Port out_valid, output, 1 bit: y holds a completed result.
REQ-008 Port out_ready, output from the consumer, input to this block, 1 bit: the consumer takes y this cycle.
REQ-009 Port y, output, 7 bits: the result.
REQ-010 Port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-011 The result SHALL be y[k] = XOR over i+j=k+8 of a0[i]&b0[j], XOR, XOR over i+j=k of a1[i]&b1[j], for k=0..6.
REQ-012 Equivalently, y SHALL equal clmul(a0,b0)[14:8] XOR clmul(a1,b1)[6:0], where clmul is the carry-less 8x8 product (15 bits).
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; busy SHALL equal (state != IDLE).
REQ-015 Acceptance: on in_valid&&in_ready, the block SHALL register all four operands, clear both 15-bit accumulators and the step counter, and go to RUN.
REQ-016 RUN step: each cycle the block SHALL process the next BPC bits j of b0 and b1, LSB first: acc0 ^= b0[j] ? (a0<<j) : 0, and likewise acc1 with a1 and b1.
REQ-017 RUN SHALL last exactly N=8/BPC cycles; after the last step the block SHALL enter DONE.
REQ-018 out_valid SHALL rise exactly N cycles after the acceptance edge; out_valid SHALL be 1 only in DONE.
REQ-019 In DONE, y SHALL be driven from registers and SHALL stay stable while out_valid&&!out_ready.
REQ-020 On out_valid&&out_ready the block SHALL go to IDLE, and in_ready SHALL be 1 in the following cycle.
REQ-021 Changes on the operand inputs while in RUN or DONE SHALL NOT affect y.
REQ-022 Input is not accepted in the cycle of the output handshake; the minimum initiation interval SHALL be N+2 cycles.
REQ-023 in_valid asserted while busy SHALL be held off (in_ready=0) without loss, provided the source holds it.
REQ-024 All-zero operands SHALL still take the full N cycles.

Reset
REQ-025 While rst_n=0 the block SHALL hold: state=IDLE, in_ready=1, out_valid=0, busy=0, y=0, accumulators=0 and counter=0.
REQ-026 Assertion of rst_n mid-RUN or mid-DONE SHALL discard the operation immediately (asynchronously), and no out_valid SHALL follow.
REQ-027 Deassertion of rst_n SHALL be synchronised externally; the first accept SHALL be possible on the first clock edge after release.

Structure
REQ-028 Package clmul_slice_pkg SHALL hold the state enum (IDLE/RUN/DONE), the constants OP_W=8, Y_W=7, ACC_W=15 and Y_OFS=8, and a reference function clmul8 for use by the bench.
REQ-029 A single sub-module, clmul_step, SHALL be instantiated twice (once per operand pair); it is combinational and computes acc ^ XOR over BPC bits of (b[j] ? a<<j : 0).
REQ-030 The top level SHALL contain only the FSM, the counter, the operand registers and the output register; no latches and no combinational in->out paths.

Verification
REQ-031 a0=b0=0x00, a1=b1=0x01 -> y=0x01, out_valid exactly N cycles after accept.
REQ-032 a0=b0=0x80, a1=b1=0x03 -> y=0x45 (x^14 gives bit 6; (1+x)^2 gives bits 0 and 2).
REQ-033 All operands 0xFF -> y=0x00 (8 terms per bit, even parity); a0=0x80, b0=0x01, a1=b1=0 -> y=0x00.
REQ-034 out_ready held 0 for 5 cycles in DONE -> y and out_valid stable, in_ready=0 throughout; then a handshake -> IDLE next cycle.
REQ-035 rst_n pulsed low in the 3rd RUN cycle (BPC=1) -> all outputs return to reset values immediately; no out_valid; next accept yields a correct result.
REQ-036 Random back-to-back operands for BPC in {1,2,4,8} against clmul8-based y -> zero mismatches and initiation interval = N+2.
